// File: rtl/ordena_pkg.sv
// Shared types and constants for the ordena_n_seq burst sorter.
// Optional feature macro: ORDENA_DESC_EN (descending order when defined).
package ordena_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int W_DEF = 9;
  localparam int N_DEF = 8;

  // Width of the word index and pass counters; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/compara_troca.sv
// Single combinational compare-swap cell used by every sorter pass.
// Macro ORDENA_DESC_EN flips the ordering so the larger value goes to lo.
module compara_troca
  import ordena_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic swap;

  // Strict comparison so equal values stay where they are.
`ifdef ORDENA_DESC_EN
  assign swap = (a < b);
`else
  assign swap = (a > b);
`endif

  assign lo = swap ? b : a;
  assign hi = swap ? a : b;

endmodule

// File: rtl/ordena_n_seq.sv
// Sequential N-word sorter: load a burst, run N odd-even transposition passes, drain.
// Macro ORDENA_DESC_EN selects descending output (handled inside compara_troca).
module ordena_n_seq
  import ordena_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int            IW   = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] pass_q;
  logic [W-1:0]  mem_q   [N];
  logic [W-1:0]  even_nx [N];
  logic [W-1:0]  odd_nx  [N];
  logic          in_hs;
  logic          out_hs;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // Even passes pair (0,1),(2,3)...; odd passes pair (1,2),(3,4)... and leave the ends alone.
  for (genvar k = 0; k < N / 2; k++) begin : g_even
    compara_troca #(.W(W)) u_ct (
      .a  (mem_q[2*k]),
      .b  (mem_q[2*k+1]),
      .lo (even_nx[2*k]),
      .hi (even_nx[2*k+1])
    );
  end

  for (genvar k = 0; k < N / 2 - 1; k++) begin : g_odd
    compara_troca #(.W(W)) u_ct (
      .a  (mem_q[2*k+1]),
      .b  (mem_q[2*k+2]),
      .lo (odd_nx[2*k+1]),
      .hi (odd_nx[2*k+2])
    );
  end

  assign odd_nx[0]   = mem_q[0];
  assign odd_nx[N-1] = mem_q[N-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (in_hs && (idx_q == LAST)) state_d = SORT;
      SORT:    if (pass_q == LAST) state_d = DRAIN;
      DRAIN:   if (out_hs && (idx_q == LAST)) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == DRAIN);
    busy      = (state_q != LOAD);
    out_last  = (state_q == DRAIN) && (idx_q == LAST);
    out_data  = (state_q == DRAIN) ? mem_q[idx_q] : '0;
  end

  // The word index is shared between LOAD and DRAIN; it always wraps back to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= '0;
      pass_q <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_hs) idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
        end
        SORT: begin
          pass_q <= (pass_q == LAST) ? '0 : pass_q + 1'b1;
        end
        DRAIN: begin
          if (out_hs) idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
        end
        default: begin
          idx_q  <= '0;
          pass_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == LOAD) && in_hs) begin
      mem_q[idx_q] <= in_data;
    end else if (state_q == SORT) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= pass_q[0] ? odd_nx[i] : even_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_ordena_n_seq.sv
// Directed table-driven bench for ordena_n_seq (W=9, N=8), including stalls, gaps and mid-sort reset.
// Honours ORDENA_DESC_EN by reading the ascending expectation tables back to front.
module tb_ordena_n_seq;

  localparam int W = 9;
  localparam int N = 8;

  typedef struct {
    logic [W-1:0] din  [N];
    logic [W-1:0] dout [N];
    bit           gaps;
    bit           stall;
    bit           junk;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int n_vec  = 0;
  int n_miss = 0;

  vec_t tbl [6];

  ordena_n_seq #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] expAt(input vec_t v, input int i);
`ifdef ORDENA_DESC_EN
    return v.dout[N-1-i];
`else
    return v.dout[i];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads one burst; returns right after the last input handshake edge (+1).
  task automatic applyStimulus(input vec_t v);
    int w;
    for (int i = 0; i < N; i++) begin
      if (v.gaps && (i % 3 == 1)) begin
        in_valid = 1'b0;
        tick();
        tick();
      end
      in_valid = 1'b1;
      in_data  = v.din[i];
      w = 0;
      while (!in_ready && w < 50) begin
        tick();
        w++;
      end
      if (!in_ready) begin
        checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = v.junk;
    in_data  = '0;
    checkOutput("busy_after_load", 32'(busy), 32'd1);
    checkOutput("in_ready_after_load", 32'(in_ready), 32'd0);
  endtask

  // out_valid must rise exactly N edges after the last input handshake edge.
  task automatic checkLatency();
    int lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("first_out_latency", 32'(lat), 32'(N));
  endtask

  task automatic drainBurst(input vec_t v);
    int i = 0;
    int k = 0;
    bit rdy;
    while (i < N && k < 100) begin
      rdy       = v.stall ? (k % 3 == 0) : 1'b1;
      out_ready = rdy;
      checkOutput("out_valid", 32'(out_valid), 32'd1);
      checkOutput("out_data", 32'(out_data), 32'(expAt(v, i)));
      checkOutput("out_last", 32'(out_last), 32'(i == N - 1));
      checkOutput("in_ready_drain", 32'(in_ready), 32'd0);
      checkOutput("busy_drain", 32'(busy), 32'd1);
      tick();
      if (rdy && out_valid === 1'b0 && i < N - 1) begin
        checkOutput("out_valid_dropped", 32'(out_valid), 32'd1);
      end
      if (rdy) i++;
      k++;
    end
    if (i < N) checkOutput("drain_timeout", 32'(i), 32'(N));
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("in_ready_after_drain", 32'(in_ready), 32'd1);
    checkOutput("out_valid_after_drain", 32'(out_valid), 32'd0);
    checkOutput("busy_after_drain", 32'(busy), 32'd0);
  endtask

  initial begin
    tbl[0].din  = '{9'd8, 9'd7, 9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1};
    tbl[0].dout = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8};
    tbl[0].gaps = 0; tbl[0].stall = 0; tbl[0].junk = 0;
    tbl[1].din  = '{9'd511, 9'd0, 9'd3, 9'd3, 9'd511, 9'd0, 9'd256, 9'd1};
    tbl[1].dout = '{9'd0, 9'd0, 9'd1, 9'd3, 9'd3, 9'd256, 9'd511, 9'd511};
    tbl[1].gaps = 0; tbl[1].stall = 1; tbl[1].junk = 0;
    tbl[2].din  = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8};
    tbl[2].dout = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8};
    tbl[2].gaps = 1; tbl[2].stall = 0; tbl[2].junk = 1;
    tbl[3].din  = '{9'd100, 9'd37, 9'd255, 9'd37, 9'd0, 9'd480, 9'd12, 9'd99};
    tbl[3].dout = '{9'd0, 9'd12, 9'd37, 9'd37, 9'd99, 9'd100, 9'd255, 9'd480};
    tbl[3].gaps = 1; tbl[3].stall = 1; tbl[3].junk = 1;
    tbl[4].din  = '{9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5};
    tbl[4].dout = '{9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5};
    tbl[4].gaps = 0; tbl[4].stall = 0; tbl[4].junk = 0;
    tbl[5].din  = '{9'd2, 9'd1, 9'd4, 9'd3, 9'd6, 9'd5, 9'd8, 9'd7};
    tbl[5].dout = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8};
    tbl[5].gaps = 0; tbl[5].stall = 1; tbl[5].junk = 0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 5; t++) begin
      $display("[TB] burst %0d", t);
      applyStimulus(tbl[t]);
      checkLatency();
      drainBurst(tbl[t]);
    end

    // Interrupt a burst during SORT pass 3, then confirm a fresh burst sorts cleanly.
    $display("[TB] reset during sort");
    applyStimulus(tbl[0]);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_out_data", 32'(out_data), 32'd0);
    applyStimulus(tbl[5]);
    checkLatency();
    drainBurst(tbl[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ordena_n_seq.md
Name: ordena_n_seq

Overview:
- Sequential N-entry sorter for W-bit unsigned words.
- Collects a burst of N words on a valid/ready input stream into an internal buffer.
- Sorts the buffer in place with N odd-even transposition passes, then streams the sorted words out on a valid/ready output.
- Sits downstream of the data source. Generalizes the two-number ordering stage by instantiating that compare-swap behaviour N/2 times in parallel per pass.

Parameters:
- W, 9: data word width in bits.
- N, 8: words per burst. Even, at least 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  W  unsigned input word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts a word this cycle.
- out_data  output  W  sorted output word.
- out_last  output  1  high with the final (N-th) word of the burst.
- busy  output  1  high in SORT and DRAIN.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=LOAD, index=0, pass counter=0.
  - in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
  - Buffer contents are don't-care.
  - Reset mid-burst or mid-sort discards all buffered data. There is no partial output.
- A word transfers on a posedge where valid && ready are both 1.
- LOAD:
  - in_ready=1.
  - Each accepted word is written to buf[index], then index increments.
  - When the N-th word is accepted: go to SORT, index=0, in_ready drops on the next cycle.
  - in_valid low stalls the state with no change.
- SORT:
  - in_ready=0, busy=1. Exactly N cycles, one pass per cycle, pass counter 0..N-1.
  - Even pass: compare-swap pairs (0,1),(2,3),…,(N-2,N-1).
  - Odd pass: compare-swap pairs (1,2),…,(N-3,N-2). buf[0] and buf[N-1] hold.
  - Compare-swap puts the smaller value at the lower index.
  - Equal values are not swapped.
  - After pass N-1: go to DRAIN with index=0.
- DRAIN:
  - out_valid=1, out_data=buf[index], out_last=(index==N-1).
  - On an out_ready handshake, index increments.
  - While out_valid && !out_ready, out_data and out_last hold stable.
  - The handshake with out_last=1 returns the block to LOAD, index=0, busy=0. in_ready=1 from the next cycle.
  - in_valid during DRAIN is ignored, because in_ready=0.
- Latency: the last input word's handshake is at cycle T. The first word appears at T+N+1 (N SORT cycles, then DRAIN registered).
- Arithmetic: unsigned W-bit comparison only. No width growth.
- Back-to-back bursts are allowed. There are no bubbles in LOAD beyond the source's own.

Optional Feature:
- Macro ORDENA_DESC_EN.
- Defined: the compare-swap puts the larger value at the lower index, so output is in descending order. Equal values are still not swapped.
- Undefined: ascending order, as described above.
- Timing and handshakes are identical in both modes.

Decomposition:
- Package ordena_pkg:
  - state enum {LOAD, SORT, DRAIN} (2 bits).
  - Default W constant.
  - Index width $clog2(N), for the index and pass counters.
- Sub-module compara_troca:
  - Purely combinational. Inputs a, b (W bits); outputs lo, hi.
  - Honours ORDENA_DESC_EN.
  - ordena_n_seq instantiates N/2 copies for even passes and N/2-1 copies for odd passes.

Test Plan:
- Reverse input, N=8: load 8,7,6,5,4,3,2,1 → outputs 1..8, first word at T+9, out_last only on 8, busy high from T+1 through the last handshake.
- Duplicates and extremes, W=9: 511,0,3,3,511,0,256,1 → 0,0,1,3,3,256,511,511.
- Backpressure: out_ready toggles 1,0,0,1,… during DRAIN → out_data/out_last stable on stall cycles; no word lost or repeated; in_ready=0 throughout.
- Input gaps and ignore: in_valid gaps during LOAD → index only advances on handshakes. in_valid=1 during SORT/DRAIN → no buffer change.
- Reset mid-op: assert rst_n=0 for 1 cycle during SORT pass 3 → next cycle in_ready=1, out_valid=0. A fresh burst of 2,1,… sorts correctly with no residue.
- ORDENA_DESC_EN defined: load 1..8 → outputs 8..1 with the same latency.
